// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx among NUM_REQ byte producers.
// Optional busy-rise watchdog enabled by defining UART_ARB_BUSY_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned IDW          = 2,
  parameter int unsigned BUSY_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     tx_wr_en,
  output logic [WIDTH-1:0]         tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy,
  output logic                     active,
  output logic [IDW-1:0]           grant_id,
  output logic                     err_timeout
);

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StWaitBusy, StWaitDone} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] last_grant_q;
  logic [IDW-1:0] win_idx;
  logic           found;
  logic           accept;
  logic           timeout_hit;
  int unsigned    idx;

  // Search starts just after the last served requester and wraps.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_grant_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        win_idx = IDW'(idx);
      end
    end
  end

  assign accept = (state_q == StIdle) && !tx_busy && found;

`ifdef UART_ARB_BUSY_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(BUSY_TIMEOUT + 1);

  logic [CntW-1:0] cnt_q;
  logic            err_q;

  assign timeout_hit = (state_q == StWaitBusy) && !tx_busy && (cnt_q == CntW'(BUSY_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if (state_q != StWaitBusy) begin
        cnt_q <= '0;
      end else if (!tx_busy) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign err_timeout = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^BUSY_TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign err_timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (accept) state_d = StLoad;
      StLoad:     state_d = StStart;
      StStart:    if (!tx_busy) state_d = StWaitBusy;
      StWaitBusy: begin
        if (tx_busy) begin
          state_d = StWaitDone;
        end else if (timeout_hit) begin
          state_d = StIdle;
        end
      end
      StWaitDone: if (!tx_busy) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = '0;
    // Gate with reset so every output reads 0 while rst_n is low.
    if (accept && rst_n) req_ready[win_idx] = 1'b1;
    tx_wr_en = (state_q == StLoad);
    tx_start = (state_q == StStart) && !tx_busy;
    active   = (state_q != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data      <= '0;
      grant_id     <= '0;
      last_grant_q <= IDW'(NUM_REQ - 1);
    end else begin
      if (accept) begin
        tx_data  <= req_data[32'(win_idx) * WIDTH +: WIDTH];
        grant_id <= win_idx;
      end
      if (((state_q == StWaitDone) && !tx_busy) || timeout_hit) begin
        last_grant_q <= grant_id;
      end
    end
  end

endmodule
